// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake and fills IF/ID.
// Define IFETCH_ALIGN_CHECK_EN to trap misaligned PCs and expose IfIdAlignErr.
module ifetch_stage #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              Clock,
  input  logic              ResetN,
  input  logic [ADDR_W-1:0] NextPcIn,
  input  logic              RedirectIn,
  input  logic              StallIn,
  input  logic              FlushIn,
  output logic [ADDR_W-1:0] PcPlus4Out,
  output logic              ImemReq,
  output logic [ADDR_W-1:0] ImemAddr,
  input  logic              ImemAck,
  input  logic [DATA_W-1:0] ImemData,
  output logic              IfIdValid,
  output logic [DATA_W-1:0] IfIdInstr,
  output logic [ADDR_W-1:0] IfIdPcPlus4
`ifdef IFETCH_ALIGN_CHECK_EN
  ,
  output logic              IfIdAlignErr
`endif
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold, StDrain} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] drain_addr_q;
  logic [DATA_W-1:0] buf_q;
  logic              ifid_valid_q;
  logic [DATA_W-1:0] ifid_instr_q;
  logic [ADDR_W-1:0] ifid_pc4_q;

  logic              misalign;
  logic              fetch_ack;
  logic [DATA_W-1:0] fetch_data;
  logic [ADDR_W-1:0] pc_plus4;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign misalign = (state_q == StFetch) && (pc_q[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // A misaligned PC completes internally as if memory had returned a zero word.
  assign fetch_ack  = ImemAck | misalign;
  assign fetch_data = misalign ? '0 : ImemData;
  assign pc_plus4   = pc_q + ADDR_W'(4);

  assign PcPlus4Out  = pc_plus4;
  assign ImemReq     = ((state_q == StFetch) && !misalign) || (state_q == StDrain);
  assign ImemAddr    = (state_q == StDrain) ? drain_addr_q : pc_q;
  assign IfIdValid   = ifid_valid_q;
  assign IfIdInstr   = ifid_instr_q;
  assign IfIdPcPlus4 = ifid_pc4_q;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      buf_q        <= '0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= '0;
      ifid_pc4_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: state_q <= StFetch;
        StFetch: begin
          if (RedirectIn) begin
            pc_q         <= NextPcIn;
            ifid_valid_q <= 1'b0;
            // An unacked request cannot be withdrawn; remember it and drain it.
            if (!fetch_ack) begin
              drain_addr_q <= pc_q;
              state_q      <= StDrain;
            end
          end else if (fetch_ack) begin
            if (StallIn) begin
              buf_q   <= fetch_data;
              state_q <= StHold;
            end else begin
              ifid_valid_q <= 1'b1;
              ifid_instr_q <= fetch_data;
              ifid_pc4_q   <= pc_plus4;
              pc_q         <= NextPcIn;
            end
          end else if (!StallIn) begin
            ifid_valid_q <= 1'b0;
          end
        end
        StHold: begin
          if (RedirectIn) begin
            pc_q         <= NextPcIn;
            ifid_valid_q <= 1'b0;
            state_q      <= StFetch;
          end else if (!StallIn) begin
            ifid_valid_q <= 1'b1;
            ifid_instr_q <= buf_q;
            ifid_pc4_q   <= pc_plus4;
            pc_q         <= NextPcIn;
            state_q      <= StFetch;
          end
        end
        StDrain: begin
          if (ImemAck) state_q <= StFetch;
          if (RedirectIn) pc_q <= NextPcIn;
        end
        default: state_q <= StIdle;
      endcase
      if (FlushIn) ifid_valid_q <= 1'b0;
    end
  end

`ifdef IFETCH_ALIGN_CHECK_EN
  logic buf_err_q;
  logic ifid_err_q;

  // Error flag follows the same buffer / IF/ID load events as the instruction word.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      buf_err_q  <= 1'b0;
      ifid_err_q <= 1'b0;
    end else if ((state_q == StFetch) && !RedirectIn && fetch_ack) begin
      if (StallIn) buf_err_q <= misalign;
      else         ifid_err_q <= misalign;
    end else if ((state_q == StHold) && !RedirectIn && !StallIn) begin
      ifid_err_q <= buf_err_q;
    end
  end

  assign IfIdAlignErr = ifid_err_q;
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// Self-checking bench for ifetch_stage: directed scenarios plus random traffic
// checked against a program-order model of the delivered instruction stream.
module tb_ifetch_stage;

  logic        Clock = 1'b0;
  logic        ResetN = 1'b0;
  logic        RedirectIn, StallIn, FlushIn, ImemAck;
  logic [31:0] tgt, ImemData, NextPcIn, PcPlus4Out, ImemAddr, IfIdInstr, IfIdPcPlus4;
  logic        ImemReq, IfIdValid;
  logic [31:0] w_pc4, w_addr, w_instr, w_ifpc4;
  logic        w_req, w_valid;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic        IfIdAlignErr, w_err;
`endif

  assign NextPcIn = RedirectIn ? tgt : PcPlus4Out;

  always #5 Clock = ~Clock;

  ifetch_stage #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0000_0000)) u_dut (
    .Clock(Clock), .ResetN(ResetN), .NextPcIn(NextPcIn), .RedirectIn(RedirectIn),
    .StallIn(StallIn), .FlushIn(FlushIn), .PcPlus4Out(PcPlus4Out), .ImemReq(ImemReq),
    .ImemAddr(ImemAddr), .ImemAck(ImemAck), .ImemData(ImemData), .IfIdValid(IfIdValid),
    .IfIdInstr(IfIdInstr), .IfIdPcPlus4(IfIdPcPlus4)
`ifdef IFETCH_ALIGN_CHECK_EN
    , .IfIdAlignErr(IfIdAlignErr)
`endif
  );

  // Second instance: reset PC at the top of the address space, zero-wait memory.
  ifetch_stage #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .Clock(Clock), .ResetN(ResetN), .NextPcIn(w_pc4), .RedirectIn(1'b0),
    .StallIn(1'b0), .FlushIn(1'b0), .PcPlus4Out(w_pc4), .ImemReq(w_req),
    .ImemAddr(w_addr), .ImemAck(w_req), .ImemData(32'h0), .IfIdValid(w_valid),
    .IfIdInstr(w_instr), .IfIdPcPlus4(w_ifpc4)
`ifdef IFETCH_ALIGN_CHECK_EN
    , .IfIdAlignErr(w_err)
`endif
  );

  int          total = 0;
  int          bad = 0;
  int          delivered = 0;
  bit          model_on = 1'b1;
  bit          pend = 1'b0;
  logic [31:0] pend_addr = '0;
  logic [31:0] exp_pc = '0;
  bit          r_rd, r_st, r_fl, r_ak;
  logic [31:0] r_t;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: apply inputs, act as memory, update the model.
  task automatic drive(input bit st, input bit rd, input bit fl, input bit ak,
                       input logic [31:0] t);
    StallIn    = st;
    RedirectIn = rd;
    FlushIn    = fl;
    tgt        = t;
    ImemAck    = ak & ImemReq;
    ImemData   = mem(ImemAddr);
    #1;
    if (pend) chk("addr_stable", ImemAddr, pend_addr);
    pend      = ImemReq & !ImemAck;
    pend_addr = ImemAddr;
    // ID consumes IF/ID this cycle; it must be the next instruction in program order.
    if (IfIdValid && !StallIn) begin
      if (model_on) begin
        chk("stream_instr", IfIdInstr, mem(exp_pc));
        chk("stream_pc4", IfIdPcPlus4, exp_pc + 32'd4);
        delivered++;
      end
      exp_pc = exp_pc + 32'd4;
    end
    if (RedirectIn) exp_pc = t;
  endtask

  task automatic tick();
    @(negedge Clock);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RedirectIn = 0; StallIn = 0; FlushIn = 0; ImemAck = 0; ImemData = '0; tgt = '0;
    repeat (2) @(negedge Clock);
    #1;
    chk_b("rst_req", ImemReq, 1'b0);
    chk_b("rst_valid", IfIdValid, 1'b0);
    chk("rst_instr", IfIdInstr, 32'h0);
    chk("rst_pc4", IfIdPcPlus4, 32'h0);
    chk("rst_pcplus4", PcPlus4Out, 32'h4);
    chk("wrap_pcplus4", w_pc4, 32'h0);
    @(negedge Clock);
    ResetN = 1'b1;

    // Zero-wait memory: IDLE cycle, then one fetch per cycle.
    drive(0, 0, 0, 1, 0);
    chk_b("idle_req", ImemReq, 1'b0);
    chk_b("wrap_idle_req", w_req, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 1, 0);
      chk_b("zw_req", ImemReq, 1'b1);
      chk("zw_addr", ImemAddr, 32'(4 * k));
      chk("wrap_addr", w_addr, 32'hFFFF_FFFC + 32'(4 * k));
      if (k > 0) begin
        chk_b("zw_valid", IfIdValid, 1'b1);
        chk("zw_pc4", IfIdPcPlus4, 32'(4 * k));
      end
      tick();
    end

    // Ack delayed two cycles, stalled on the ack cycle and the two after.
    drive(1, 0, 0, 0, 0); chk("st_pc4_held", IfIdPcPlus4, 32'h10); tick();
    drive(1, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 1, 0); chk("st_ack_addr", ImemAddr, 32'h10); tick();
    for (int i = 0; i < 3; i++) begin
      drive(i < 2, 0, 0, 0, 0);
      chk_b("hold_req", ImemReq, 1'b0);
      chk_b("hold_valid", IfIdValid, 1'b1);
      chk("hold_pc4", IfIdPcPlus4, 32'h10);
      chk("hold_instr", IfIdInstr, mem(32'hC));
      tick();
    end
    drive(0, 1, 0, 1, 32'h8);
    chk("rel_instr", IfIdInstr, mem(32'h10));
    chk("rel_pc4", IfIdPcPlus4, 32'h14);
    chk("rel_addr", ImemAddr, 32'h14);
    tick();

    // Redirect to 0x100 while the fetch of 0x8 is outstanding.
    drive(0, 0, 0, 0, 0); chk("dr_addr0", ImemAddr, 32'h8); chk_b("dr_v0", IfIdValid, 1'b0); tick();
    drive(0, 1, 0, 0, 32'h100); chk("dr_addr1", ImemAddr, 32'h8); tick();
    drive(0, 0, 0, 0, 0); chk("dr_addr2", ImemAddr, 32'h8); chk_b("dr_req2", ImemReq, 1'b1); tick();
    drive(0, 0, 0, 1, 0); chk("dr_addr3", ImemAddr, 32'h8); tick();
    drive(0, 0, 0, 1, 0); chk("dr_tgt", ImemAddr, 32'h100); chk_b("dr_v4", IfIdValid, 1'b0); tick();

    // Redirect and stall together in HOLD: redirect wins.
    drive(1, 0, 0, 1, 0); chk("hr_pc4", IfIdPcPlus4, 32'h104); tick();
    drive(1, 1, 0, 0, 32'h200); chk_b("hr_req", ImemReq, 1'b0); tick();
    drive(0, 0, 0, 1, 0);
    chk("hr_addr", ImemAddr, 32'h200);
    chk("hr_pcplus4", PcPlus4Out, 32'h204);
    chk_b("hr_valid", IfIdValid, 1'b0);
    tick();

    // Flush overrides a same-cycle IF/ID load but leaves the PC advancing.
    drive(0, 0, 1, 1, 0); chk("fl_instr", IfIdInstr, mem(32'h200)); tick();
    drive(0, 1, 0, 1, 32'h300); chk_b("fl_valid", IfIdValid, 1'b0); chk("fl_addr", ImemAddr, 32'h208);
    tick();

`ifdef IFETCH_ALIGN_CHECK_EN
    drive(0, 1, 0, 1, 32'h102); tick();
    model_on = 1'b0;
    drive(0, 0, 0, 0, 0); chk_b("al_req", ImemReq, 1'b0); tick();
    drive(0, 1, 0, 0, 32'h300);
    chk_b("al_valid", IfIdValid, 1'b1);
    chk("al_instr", IfIdInstr, 32'h0);
    chk_b("al_err", IfIdAlignErr, 1'b1);
    tick();
    model_on = 1'b1;
    drive(0, 0, 0, 1, 0); chk("al_addr", ImemAddr, 32'h300); tick();
    drive(0, 0, 0, 1, 0); chk_b("al_err_clr", IfIdAlignErr, 1'b0); tick();
`endif

    // Random traffic against the program-order model.
    for (int c = 0; c < 3000; c++) begin
      r_rd = ($urandom_range(0, 15) == 0);
      r_st = !r_rd && ($urandom_range(0, 3) == 0);
      r_fl = r_rd && ($urandom_range(0, 1) == 1);
      r_ak = ($urandom_range(0, 1) == 1);
      r_t  = $urandom & 32'h0000_FFFC;
      drive(r_st, r_rd, r_fl, r_ak, r_t);
      tick();
    end
    chk_b("throughput", delivered > 300, 1'b1);

    // Asynchronous reset while a request is outstanding.
    drive(0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0);
    chk_b("pre_rst_req", ImemReq, 1'b1);
    #2 ResetN = 1'b0;
    #1;
    chk_b("async_req", ImemReq, 1'b0);
    chk_b("async_valid", IfIdValid, 1'b0);
    chk("async_pcplus4", PcPlus4Out, 32'h4);
    pend = 1'b0;
    exp_pc = '0;
    @(negedge Clock);
    ResetN = 1'b1;
    drive(0, 0, 0, 1, 0); chk_b("re_idle", ImemReq, 1'b0); tick();
    drive(0, 0, 0, 1, 0); chk("re_addr", ImemAddr, 32'h0); tick();
    drive(0, 0, 0, 1, 0); chk("re_pc4", IfIdPcPlus4, 32'h4); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
